pb_port_out_fifo: RTL and testbench

//  Output-port stage downstream of the PicoBlaze (kcpsm6) core. Decodes processor writes to a

---
 rtl/pb_io_pkg.sv | 19 +
 rtl/pb_sync_fifo_core.sv | 64 ++++++
 rtl/pb_port_out_fifo.sv | 99 +++++++++
 tb/tb_pb_port_out_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pb_io_pkg.sv
// PicoBlaze I/O shared constants: port IDs, status and control bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pb_io_pkg;

  localparam logic [7:0] DATA_PORT_ID_DEF   = 8'h05;
  localparam logic [7:0] STATUS_PORT_ID_DEF = 8'h06;

  // Status byte layout: {level[3:0], 0, overflow, full, empty}
  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_LVL_LSB = 4;

  // Control byte written to the status port
  localparam int CTL_CLR_OVF = 0;
  localparam int CTL_FLUSH   = 1;

endpackage

// File: rtl/pb_sync_fifo_core.sv
// Byte FIFO core: storage, pointers, occupancy count, registered full/empty, flush.
// Latency: count/full/empty update on the edge after push/pop; head_nxt is combinational look-ahead.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module pb_sync_fifo_core #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [7:0]      din,
  output logic [ADDR_W:0] count,
  output logic [ADDR_W:0] count_nxt,
  output logic            full,
  output logic            empty,
  output logic [7:0]      head_nxt
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic              push_ok, pop_ok;

  // Next-state for pointers and count; head_nxt bypasses din when the new byte becomes the head
  always_comb begin
    push_ok    = push & ~flush & (~full | pop);
    pop_ok     = pop & ~empty & ~flush;
    wr_ptr_nxt = wr_ptr + ADDR_W'(push_ok);
    rd_ptr_nxt = rd_ptr + ADDR_W'(pop_ok);
    count_nxt  = count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end
    head_nxt = (push_ok && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
  end

  // Storage write; contents need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer/count state with full/empty registered from the next count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      full   <= (count_nxt == FULL_CNT);
      empty  <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/pb_port_out_fifo.sv
// PicoBlaze output port with FIFO buffering, FWFT valid/ready drain and a pollable status port.
// Latency: push into empty FIFO shows on dout one edge later; status byte registered one cycle after port_id.
// Backpressure: consumer stalls via dout_ready; pushes while full without a pop are dropped and flag overflow.
module pb_port_out_fifo
  import pb_io_pkg::*;
#(
  parameter logic [7:0] DATA_PORT_ID   = DATA_PORT_ID_DEF,
  parameter logic [7:0] STATUS_PORT_ID = STATUS_PORT_ID_DEF,
  parameter int         DEPTH          = 8,
  parameter int         ADDR_W         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  logic            push, pop, ctl_wr, clr_ovf, flush;
  logic [ADDR_W:0] count, count_nxt;
  logic [7:0]      head_nxt;
  logic [7:0]      status;
  logic            unused_rd;

  // Status reads have no side effect
  assign unused_rd = read_strobe;

  assign push    = write_strobe & (port_id == DATA_PORT_ID);
  assign pop     = dout_valid & dout_ready;
  assign ctl_wr  = write_strobe & (port_id == STATUS_PORT_ID);
  assign clr_ovf = ctl_wr & out_port[CTL_CLR_OVF];
  assign flush   = ctl_wr & out_port[CTL_FLUSH];

  pb_sync_fifo_core #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .din       (out_port),
    .count     (count),
    .count_nxt (count_nxt),
    .full      (full),
    .empty     (empty),
    .head_nxt  (head_nxt)
  );

  // Assemble the status byte from the current registered state
  always_comb begin
    status                    = '0;
    status[ST_EMPTY]          = empty;
    status[ST_FULL]           = full;
    status[ST_OVF]            = overflow;
    status[ST_LVL_LSB +: 4]   = 4'(count);
  end

  // Sticky overflow on a dropped push; an explicit clear takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // FWFT output register: present the next head; hold last byte when the FIFO runs dry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= (count_nxt != '0);
      if (count_nxt != '0) dout <= head_nxt;
    end
  end

  // Status port read data follows port_id every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_port <= '0;
    end else begin
      in_port <= (port_id == STATUS_PORT_ID) ? status : 8'h00;
    end
  end

endmodule

// File: tb/tb_pb_port_out_fifo.sv
module tb_pb_port_out_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       full;
  logic       empty;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  pb_port_out_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pid;
    logic       ws;
    logic [7:0] dat;
    logic       rdy;
    logic       e_vld;
    logic [7:0] e_dout;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
    logic [7:0] e_in;
  } vec_t;

  vec_t vecs[12];
  logic [7:0] q[$];
  logic       movf;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] pid, input logic ws, input logic [7:0] d, input logic rdy);
    port_id      = pid;
    write_strobe = ws;
    out_port     = d;
    dout_ready   = rdy;
    read_strobe  = (pid == 8'h06) && !ws;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference-model cycle: apply inputs, advance, compare with the queue model
  task automatic model_cycle(input logic ws, input logic [7:0] d, input logic rdy);
    logic pop_m, push_m;
    pop_m  = (q.size() > 0) && rdy;
    push_m = 1'b0;
    if (ws) begin
      if (q.size() < 8 || pop_m) push_m = 1'b1;
      else movf = 1'b1;
    end
    drive(ws ? 8'h05 : 8'h00, ws, d, rdy);
    step();
    if (pop_m) void'(q.pop_front());
    if (push_m) q.push_back(d);
    chk("rnd_vld", {7'd0, dout_valid}, {7'd0, q.size() > 0});
    if (q.size() > 0) chk("rnd_dout", dout, q[0]);
    chk("rnd_full", {7'd0, full}, {7'd0, q.size() == 8});
    chk("rnd_empty", {7'd0, empty}, {7'd0, q.size() == 0});
    chk("rnd_ovf", {7'd0, overflow}, {7'd0, movf});
  endtask

  initial begin
    // pid ws dat rdy | vld dout full empty ovf in_port
    vecs[0]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{8'h05, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{8'h06, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h10};
    vecs[3]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{8'h05, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{8'h05, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{8'h05, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{8'h06, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h30};
    vecs[8]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{8'h05, 1'b1, 8'h44, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{8'h06, 1'b1, 8'h02, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 8'h20};
    vecs[11] = '{8'h06, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 8'h01};

    rst = 1'b1;
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_in_port", in_port, 8'h00);
    chk("rst_dout", dout, 8'h00);
    chk("rst_vld", {7'd0, dout_valid}, 8'h00);
    chk("rst_full", {7'd0, full}, 8'h00);
    chk("rst_empty", {7'd0, empty}, 8'h01);
    chk("rst_ovf", {7'd0, overflow}, 8'h00);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].pid, vecs[i].ws, vecs[i].dat, vecs[i].rdy);
      step();
      chk($sformatf("v%0d_vld", i), {7'd0, dout_valid}, {7'd0, vecs[i].e_vld});
      chk($sformatf("v%0d_dout", i), dout, vecs[i].e_dout);
      chk($sformatf("v%0d_full", i), {7'd0, full}, {7'd0, vecs[i].e_full});
      chk($sformatf("v%0d_empty", i), {7'd0, empty}, {7'd0, vecs[i].e_empty});
      chk($sformatf("v%0d_ovf", i), {7'd0, overflow}, {7'd0, vecs[i].e_ovf});
      chk($sformatf("v%0d_in", i), in_port, vecs[i].e_in);
    end

    // Fill past capacity: 8 accepted, 9th dropped
    for (int i = 1; i <= 9; i++) begin
      drive(8'h05, 1'b1, 8'(i), 1'b0);
      step();
      if (i == 7) chk("fill7_full", {7'd0, full}, 8'h00);
      if (i == 8) chk("fill8_full", {7'd0, full}, 8'h01);
      if (i == 8) chk("fill8_ovf", {7'd0, overflow}, 8'h00);
    end
    chk("ovf_set", {7'd0, overflow}, 8'h01);
    chk("ovf_full", {7'd0, full}, 8'h01);
    drive(8'h06, 1'b0, 8'h00, 1'b0);
    step();
    chk("ovf_status", in_port, 8'h86);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_vld", {7'd0, dout_valid}, 8'h01);
      chk("drain_dout", dout, 8'(i));
      drive(8'h00, 1'b0, 8'h00, 1'b1);
      step();
    end
    chk("drain_empty", {7'd0, empty}, 8'h01);
    chk("drain_vld_end", {7'd0, dout_valid}, 8'h00);

    // Clear overflow via control write
    drive(8'h06, 1'b1, 8'h01, 1'b0);
    step();
    chk("clr_ovf", {7'd0, overflow}, 8'h00);

    // Push while full with simultaneous pop
    for (int i = 1; i <= 8; i++) begin
      drive(8'h05, 1'b1, 8'(i), 1'b0);
      step();
    end
    chk("pp_full_pre", {7'd0, full}, 8'h01);
    drive(8'h05, 1'b1, 8'h55, 1'b1);
    step();
    chk("pp_full_post", {7'd0, full}, 8'h01);
    chk("pp_ovf", {7'd0, overflow}, 8'h00);
    for (int i = 2; i <= 9; i++) begin
      chk("pp_dout", dout, (i == 9) ? 8'h55 : 8'(i));
      drive(8'h00, 1'b0, 8'h00, 1'b1);
      step();
    end
    chk("pp_empty", {7'd0, empty}, 8'h01);

    // Flush with 4 queued
    for (int i = 0; i < 4; i++) begin
      drive(8'h05, 1'b1, 8'hA1 + 8'(i), 1'b0);
      step();
    end
    drive(8'h06, 1'b1, 8'h02, 1'b0);
    step();
    chk("flush_empty", {7'd0, empty}, 8'h01);
    chk("flush_vld", {7'd0, dout_valid}, 8'h00);

    // Asynchronous reset mid-stream with 3 queued
    for (int i = 0; i < 3; i++) begin
      drive(8'h05, 1'b1, 8'hC1 + 8'(i), 1'b0);
      step();
    end
    drive(8'h06, 1'b0, 8'h00, 1'b0);
    step();
    chk("pre_rst_status", in_port, 8'h30);
    rst = 1'b1;
    #1;
    chk("arst_empty", {7'd0, empty}, 8'h01);
    chk("arst_vld", {7'd0, dout_valid}, 8'h00);
    chk("arst_in_port", in_port, 8'h00);
    drive(8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_empty", {7'd0, empty}, 8'h01);

    // Random ready with back-to-back pushes against a queue model
    movf = 1'b0;
    q.delete();
    for (int i = 0; i < 64; i++) begin
      model_cycle(1'b1, 8'h80 + 8'(i), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 12; i++) begin
      model_cycle(1'b0, 8'h00, 1'b1);
    end
    chk("rnd_final_empty", {7'd0, empty}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
